bcd_to_bin: RTL
===============

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 2, giving the number of packed BCD digits accepted per transaction.
REQ-002 SHALL have parameter OUT_W, default 7, giving the binary result width; OUT_W SHALL hold 10^DIGITS-1.
REQ-003 SHALL have parameter MAX_VAL, default 59, giving the largest in-range result.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit, asserted when bcd_in holds a request.
REQ-007 SHALL have port bcd_in, input, 4*DIGITS bits, packed BCD with the most significant digit in the top nibble.
REQ-008 SHALL have port in_ready, output, 1 bit, asserted when the block can accept a request.
REQ-009 SHALL have port out_valid, output, 1 bit, asserted when a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit, asserted when the consumer accepts the result.
REQ-011 SHALL have port bin_out, output, OUT_W bits, the binary result.
REQ-012 SHALL have port err_digit, output, 1 bit, set when any input nibble exceeds 9.
REQ-013 SHALL have port err_range, output, 1 bit, set when the result exceeds MAX_VAL.

Function
REQ-014 SHALL implement an FSM with three states: IDLE, CONV and HOLD.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-016 In IDLE, when in_valid=1, the block SHALL:
- register bcd_in;
- clear the accumulator, digit index and error flags;
- load the digit index with DIGITS-1;
- go to CONV.
REQ-017 In CONV, on each clock the block SHALL compute acc <= acc*10 + nibble[index], processing the most significant nibble first, and SHALL decrement the index.
REQ-018 In CONV, any processed nibble greater than 9 SHALL latch an internal digit-error flag.
REQ-019 When the index-0 nibble is processed, the FSM SHALL go to HOLD.
REQ-020 Latency: out_valid SHALL rise exactly DIGITS clocks after the accepting edge.
REQ-021 In HOLD, out_valid SHALL be 1, and bin_out, err_digit and err_range SHALL be stable until out_valid=1 and out_ready=1 are sampled together; the FSM SHALL then return to IDLE.
REQ-022 When the digit-error flag is set, bin_out SHALL be 0, err_digit SHALL be 1 and err_range SHALL be 0.
REQ-023 When no digit error occurred, bin_out SHALL be acc truncated to OUT_W bits, and err_range SHALL be 1 exactly when acc > MAX_VAL.
REQ-024 The internal accumulator SHALL be wide enough that nibble values 10-15 never overflow before truncation.
REQ-025 A new request SHALL NOT be accepted in the cycle in which a result is consumed; in_ready SHALL rise the cycle after.
REQ-026 in_valid and bcd_in SHALL be ignored outside IDLE; changes to bcd_in during CONV SHALL NOT affect the result.
REQ-027 When not in HOLD, out_valid SHALL be 0; bin_out, err_digit and err_range SHALL retain their last values.

Reset
REQ-028 While rst_n=0, the FSM SHALL be in IDLE, in_ready SHALL be 1, and out_valid, bin_out, err_digit, err_range, the accumulator and the index SHALL all be 0.
REQ-029 Asserting rst_n mid-CONV or mid-HOLD SHALL abort the transaction immediately, and no out_valid SHALL follow from it.
REQ-030 After rst_n rises, the first clock edge SHALL already be able to accept a request.

Verification
REQ-031 bcd_in=8'h42 with out_ready=1 -> out_valid after 2 clocks with bin_out=42, err_digit=0, err_range=0.
REQ-032 bcd_in=8'h59 -> bin_out=59 with no errors; bcd_in=8'h60 -> bin_out=60 with err_range=1.
REQ-033 bcd_in=8'h3A -> err_digit=1, err_range=0, bin_out=0.
REQ-034 bcd_in=8'h17 with out_ready held low for 5 clocks -> out_valid and bin_out=17 stable throughout; in_ready=0 throughout; in_ready=1 one clock after out_ready rises.
REQ-035 rst_n pulsed low one clock after accepting 8'h25 -> no out_valid occurs; the next request 8'h00 -> bin_out=0 with no errors.
REQ-036 Back-to-back requests 8'h01 then 8'h99 (with DIGITS=2, OUT_W=7) -> bin_out=1, then bin_out=99 with err_range=1, both in order.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Serial packed-BCD to binary converter, one digit per clock, MS digit first; result DIGITS clocks after accept.
// Valid/ready on both sides: a held result stalls the block (in_ready=0) until the consumer takes it.
module bcd_to_bin #(
  parameter int DIGITS  = 2,
  parameter int OUT_W   = 7,
  parameter int MAX_VAL = 59
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  err_digit,
  output logic                  err_range
);

  // Headroom for nibbles 10..15: worst case stays below 2*10^DIGITS.
  localparam int ACC_W = $clog2(16 * (10 ** DIGITS));
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [ACC_W-1:0] TEN     = ACC_W'(10);
  localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t              state_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q;
  logic                derr_q, derr_d;
  logic                in_ready_q, out_valid_q;
  logic [OUT_W-1:0]    bin_out_q;
  logic                err_digit_q, err_range_q;
  logic [3:0]          nib;

  always_comb begin
    nib    = bcd_q[4*idx_q +: 4];
    acc_d  = acc_q * TEN + {{(ACC_W-4){1'b0}}, nib};
    derr_d = derr_q | (nib > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      derr_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bin_out_q   <= '0;
      err_digit_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bcd_q      <= bcd_in;
            acc_q      <= '0;
            idx_q      <= IDX_W'(DIGITS - 1);
            derr_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          acc_q  <= acc_d;
          derr_q <= derr_d;
          idx_q  <= idx_q - IDX_W'(1);
          if (idx_q == '0) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            if (derr_d) begin
              bin_out_q   <= '0;
              err_digit_q <= 1'b1;
              err_range_q <= 1'b0;
            end else begin
              bin_out_q   <= acc_d[OUT_W-1:0];
              err_digit_q <= 1'b0;
              err_range_q <= (acc_d > MAX_ACC);
            end
          end
        end
        HOLD: begin
          // in_ready only returns on the edge after consumption, so no same-cycle accept.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;
  assign err_digit = err_digit_q;
  assign err_range = err_range_q;

endmodule
